// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with hold-time budget.
// One-hot ownership of a shared resource is granted to the first requester
// found above the last owner (wrapping), held until done/drop/timeout, and
// always followed by a one-cycle idle gap before the next owner.
module rr_grant_arbiter #(
   parameter  int WIDTH    = 4,
   parameter  int MAX_HOLD = 16,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic [WIDTH-1:0] req_i,
   input  logic             done_i,
   output logic [WIDTH-1:0] grant_o,
   output logic             grant_val_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             timeout_o
);

   // Hold counter only needs to reach MAX_HOLD-1; keep one bit when disabled.
   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t           state_q,     state_d;
   logic [IDX_W-1:0] ptr_q,       ptr_d;
   logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic [WIDTH-1:0] grant_q,     grant_d;
   logic             grant_val_q, grant_val_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic             timeout_q,   timeout_d;

   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] masked_req;
   logic [IDX_W-1:0] win_idx;
   logic [WIDTH-1:0] win_onehot;
   logic             win_found;
   logic             owner_req;
   logic             waiters;
   logic             timeout_hit;
   logic             release_now;

   // Priority mask: indices strictly above the last owner search first.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves it unassigned would infer a latch.
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask[i] = (i > int'(ptr_q));
      end
   end

   assign masked_req = req_i & mask;

   // Winner: lowest set bit above ptr, otherwise lowest set bit overall.
   always_comb begin
      win_idx    = '0;
      win_onehot = '0;
      win_found  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!win_found && masked_req[i]) begin
            win_idx       = IDX_W'(i);
            win_onehot[i] = 1'b1;
            win_found     = 1'b1;
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (!win_found && req_i[i]) begin
            win_idx       = IDX_W'(i);
            win_onehot[i] = 1'b1;
            win_found     = 1'b1;
         end
      end
   end

   // Release decode while granting; timeout needs someone else waiting.
   assign owner_req   = req_i[grant_idx_q];
   assign waiters     = |(req_i & ~grant_q);
   assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && waiters;
   assign release_now = done_i || !owner_req || timeout_hit;

   // Next-state and registered-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      grant_d     = grant_q;
      grant_val_d = grant_val_q;
      grant_idx_d = grant_idx_q;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               grant_d     = win_onehot;
               grant_idx_d = win_idx;
               grant_val_d = 1'b1;
               hold_cnt_d  = '0;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               ptr_d       = grant_idx_q;
               grant_d     = '0;
               grant_val_d = 1'b0;
               state_d     = ST_IDLE;
               // Forced release is flagged only when nothing else ended the grant.
               timeout_d   = timeout_hit && !done_i && owner_req;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the grant asynchronously.
   always_ff @(posedge clk_i or posedge arst_i) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (arst_i) begin
         state_q     <= ST_IDLE;
         ptr_q       <= IDX_W'(WIDTH - 1);
         hold_cnt_q  <= '0;
         grant_q     <= '0;
         grant_val_q <= 1'b0;
         grant_idx_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         grant_q     <= grant_d;
         grant_val_q <= grant_val_d;
         grant_idx_q <= grant_idx_d;
         timeout_q   <= timeout_d;
      end
   end

   assign grant_o     = grant_q;
   assign grant_val_o = grant_val_q;
   assign grant_idx_o = grant_idx_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_rr_grant_arbiter;

   localparam int W  = 4;
   localparam int MH = 16;

   logic         clk;
   logic         arst;
   logic [W-1:0] req;
   logic         done;
   logic [W-1:0] grant_o;
   logic         grant_val_o;
   logic [1:0]   grant_idx_o;
   logic         timeout_o;

   int tests_run    = 0;
   int tests_failed = 0;

   rr_grant_arbiter #(
      .WIDTH    (W),
      .MAX_HOLD (MH)
   ) dut (
      .clk_i       (clk),
      .arst_i      (arst),
      .req_i       (req),
      .done_i      (done),
      .grant_o     (grant_o),
      .grant_val_o (grant_val_o),
      .grant_idx_o (grant_idx_o),
      .timeout_o   (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the resource, who owned it last, how many
   // cycles the owner has held it so far, and whether the last release was forced.
   typedef struct packed {
      logic busy;
      int   owner;
      int   last;
      int   held;
      logic tout;
      int   idx;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_reset();
      mstate_t r;
      r.busy  = 1'b0;
      r.owner = 0;
      r.last  = W - 1;
      r.held  = 0;
      r.tout  = 1'b0;
      r.idx   = 0;
      return r;
   endfunction

   function automatic mstate_t model_next(mstate_t s, logic [W-1:0] rq, logic dn);
      mstate_t    n;
      logic       found;
      logic       waiting;
      logic       tmo;
      logic       keep;
      logic [W-1:0] own_bit;
      int         c;
      n      = s;
      n.tout = 1'b0;
      if (!s.busy) begin
         found = 1'b0;
         for (int k = 1; k <= W; k++) begin
            c = (s.last + k) % W;
            if (!found && rq[c]) begin
               found   = 1'b1;
               n.busy  = 1'b1;
               n.owner = c;
               n.idx   = c;
               n.held  = 0;
            end
         end
      end else begin
         own_bit = '0;
         own_bit[s.owner] = 1'b1;
         waiting = (rq & ~own_bit) != '0;
         tmo     = (MH != 0) && (s.held >= MH - 1) && waiting;
         keep    = rq[s.owner];
         if (dn || !keep || tmo) begin
            n.tout = tmo && !dn && keep;
            n.last = s.owner;
            n.busy = 1'b0;
         end else begin
            n.held = s.held + 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge arst) begin
      if (arst) m <= model_reset();
      else      m <= model_next(m, req, done);
   end

   logic [W-1:0] exp_grant;
   always_comb begin
      exp_grant = '0;
      if (m.busy) exp_grant[m.owner] = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req  = '0;
      done = 1'b0;
      arst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic test_reset();
      req  = '0;
      done = 1'b0;
      arst = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({grant_o, grant_val_o, grant_idx_o, timeout_o} !== 8'b0) begin
         tests_failed++;
         $display("FAIL reset_values: grant=%b val=%b idx=%0d tout=%b, expected all zero",
                  grant_o, grant_val_o, grant_idx_o, timeout_o);
      end
      @(negedge clk);
      arst = 1'b0;
      tick();
      tick();
      tests_run++;
      if (grant_o !== 4'b0000 || grant_val_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_no_req: grant=%b val=%b, expected 0000/0", grant_o, grant_val_o);
      end
   endtask

   task automatic test_reset_priority();
      int seq[$];
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (grant_o !== exp_grant || timeout_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_cycle%0d: grant=%b tout=%b, expected %b/0", i, grant_o, timeout_o, exp_grant);
         end
         if (grant_val_o) seq.push_back(int'(grant_idx_o));
         done = grant_val_o;
      end
      done = 1'b0;
      tests_run++;
      if (seq.size() != 5 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[4] != 0) begin
         tests_failed++;
         $display("FAIL prio_order: got %0d grants %p, expected 5 grants 0,1,2,3,0", seq.size(), seq);
      end
   endtask

   task automatic test_wrap_search();
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'b0011;
      tick();
      tests_run++;
      if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_gap: grant=%b tout=%b, expected 0000/0", grant_o, timeout_o);
      end
      tick();
      tests_run++;
      if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0) begin
         tests_failed++;
         $display("FAIL wrap_to_0: grant=%b idx=%0d, expected 0001/0", grant_o, grant_idx_o);
      end
      req = 4'b0010;
      tick();
      tick();
      tests_run++;
      if (grant_o !== 4'b0010 || grant_idx_o !== 2'd1) begin
         tests_failed++;
         $display("FAIL wrap_then_1: grant=%b idx=%0d, expected 0010/1", grant_o, grant_idx_o);
      end
      req = 4'b0100;
      tick();
      tests_run++;
      if (grant_idx_o !== 2'd1 || grant_val_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL idx_hold_idle: idx=%0d val=%b, expected 1/0", grant_idx_o, grant_val_o);
      end
      tick();
      tests_run++;
      if (grant_o !== 4'b0100 || grant_idx_o !== 2'd2) begin
         tests_failed++;
         $display("FAIL lone_req_2: grant=%b idx=%0d, expected 0100/2", grant_o, grant_idx_o);
      end
   endtask

   task automatic test_timeout();
      int cnt;
      do_reset();
      req = 4'b0010;
      tick();
      cnt = 0;
      while (grant_o === 4'b0010 && cnt < 40) begin
         cnt++;
         if (cnt == 3) req = 4'b1010;
         tick();
      end
      tests_run++;
      if (cnt != MH) begin
         tests_failed++;
         $display("FAIL timeout_hold_len: held %0d cycles, expected %0d", cnt, MH);
      end
      tests_run++;
      if (grant_o !== 4'b0000 || timeout_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_pulse: grant=%b tout=%b, expected 0000/1", grant_o, timeout_o);
      end
      tick();
      tests_run++;
      if (grant_o !== 4'b1000 || timeout_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_next_owner: grant=%b tout=%b, expected 1000/0", grant_o, timeout_o);
      end
   endtask

   task automatic test_no_waiter();
      int bad;
      do_reset();
      req = 4'b0100;
      tick();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (grant_o !== 4'b0100 || timeout_o !== 1'b0) bad++;
         if (i < 39) tick();
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL no_waiter_hold: %0d bad cycles of 40, expected 0", bad);
      end
      req = 4'b0101;
      tick();
      tests_run++;
      if (grant_o !== 4'b0000 || timeout_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL late_waiter_timeout: grant=%b tout=%b, expected 0000/1", grant_o, timeout_o);
      end
      tick();
      tests_run++;
      if (grant_o !== 4'b0001 || timeout_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL late_waiter_grant: grant=%b tout=%b, expected 0001/0", grant_o, timeout_o);
      end
   endtask

   task automatic test_drop_and_tie();
      do_reset();
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      tests_run++;
      if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_release: grant=%b tout=%b, expected 0000/0", grant_o, timeout_o);
      end
      // done_i in the timeout cycle
      req = 4'b0001;
      tick();
      req = 4'b0011;
      for (int k = 2; k <= MH; k++) tick();
      tests_run++;
      if (grant_o !== 4'b0001) begin
         tests_failed++;
         $display("FAIL tie_done_pre: grant=%b, expected 0001", grant_o);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      tests_run++;
      if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL tie_done: grant=%b tout=%b, expected 0000/0", grant_o, timeout_o);
      end
      tick();
      tests_run++;
      if (grant_o !== 4'b0010) begin
         tests_failed++;
         $display("FAIL tie_done_next: grant=%b, expected 0010", grant_o);
      end
      // owner drops its request in the timeout cycle
      for (int k = 2; k <= MH; k++) tick();
      req = 4'b0001;
      tick();
      tests_run++;
      if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL tie_drop: grant=%b tout=%b, expected 0000/0", grant_o, timeout_o);
      end
      tick();
      tests_run++;
      if (grant_o !== 4'b0001) begin
         tests_failed++;
         $display("FAIL tie_drop_next: grant=%b, expected 0001", grant_o);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b1000;
      tick();
      tests_run++;
      if (grant_o !== 4'b1000) begin
         tests_failed++;
         $display("FAIL areset_pre: grant=%b, expected 1000", grant_o);
      end
      #1;
      arst = 1'b1;
      #1;
      tests_run++;
      if (grant_o !== 4'b0000 || grant_val_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_async_drop: grant=%b val=%b, expected 0000/0", grant_o, grant_val_o);
      end
      req = 4'b1001;
      @(negedge clk);
      arst = 1'b0;
      tick();
      tests_run++;
      if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0) begin
         tests_failed++;
         $display("FAIL areset_first_grant: grant=%b idx=%0d, expected 0001/0", grant_o, grant_idx_o);
      end
   endtask

   task automatic test_random();
      int timeouts;
      do_reset();
      timeouts = 0;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(15) == 0) req[b] = ~req[b];
         end
         done = ($urandom_range(19) == 0);
         tick();
         tests_run++;
         if (grant_o !== exp_grant || grant_val_o !== m.busy ||
             grant_idx_o !== 2'(m.idx) || timeout_o !== m.tout) begin
            tests_failed++;
            $display("FAIL rand_cycle%0d: grant=%b val=%b idx=%0d tout=%b, expected %b/%b/%0d/%b",
                     i, grant_o, grant_val_o, grant_idx_o, timeout_o,
                     exp_grant, m.busy, m.idx, m.tout);
         end
         tests_run++;
         if (!$onehot0(grant_o) || grant_val_o !== (|grant_o) ||
             (grant_val_o && grant_o !== (4'b0001 << grant_idx_o))) begin
            tests_failed++;
            $display("FAIL rand_invariant%0d: grant=%b val=%b idx=%0d", i, grant_o, grant_val_o, grant_idx_o);
         end
         if (m.tout) timeouts++;
      end
      done = 1'b0;
      $display("[TB] random traffic produced %0d forced releases", timeouts);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      arst = 1'b1;
      req  = '0;
      done = 1'b0;
      test_reset();
      test_reset_priority();
      test_wrap_search();
      test_timeout();
      test_no_waiter();
      test_drop_and_tie();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one downstream resource, such as a priority-encoder datapath, between `WIDTH` requesters. Ownership is granted one-hot and held until the owner releases it, drops its request, or exceeds a hold budget while others wait. Rotating priority gives every requester a bounded wait. The block sits between requester ports and the shared resource's input mux.

## Interface
- `WIDTH`, default 4: number of requesters; must be ≥ 2.
- `MAX_HOLD`, default 16: maximum number of GRANT cycles before a forced release when others are waiting; 0 disables the timeout.
- `IDX_W`, default `$clog2(WIDTH)`: width of the index output; localparam, not overridable.

Ports:
- `clk_i` input 1: the single clock; everything is on its rising edge.
- `arst_i` input 1: reset, asynchronous and active-high.
- `req_i` input `WIDTH`: request per requester, level-sensitive.
- `done_i` input 1: owner finished; sampled only in GRANT.
- `grant_o` output `WIDTH`: one-hot ownership, registered.
- `grant_val_o` output 1: high when `grant_o` is nonzero.
- `grant_idx_o` output `IDX_W`: binary index of the owner; holds its last value while idle.
- `timeout_o` output 1: one-cycle pulse marking a forced release.

## Operation
- **States.** IDLE and GRANT. Registers: `state`, `ptr` (`IDX_W`, last owner), `hold_cnt` (`$clog2(MAX_HOLD+1)` bits), and all outputs.
- **Reset (async).**
  - `state`=IDLE, `ptr`=`WIDTH-1`, so requester 0 has first priority.
  - `hold_cnt`=0, `grant_o`=0, `grant_val_o`=0, `grant_idx_o`=0, `timeout_o`=0.
- **IDLE.**
  - If `req_i`==0, stay in IDLE.
  - Otherwise the winner is the first set bit of `req_i` searching upward from `ptr+1`, wrapping modulo `WIDTH`.
  - Implementation: a right-priority pick on `req_i & mask`, where `mask` covers indices above `ptr`. If that result is 0, pick the lowest set bit of unmasked `req_i`.
  - Register `grant_o`=one-hot(winner), `grant_idx_o`=winner, `grant_val_o`=1, `hold_cnt`=0, and go to GRANT.
- **GRANT.** `hold_cnt` increments each cycle and saturates. Release conditions, evaluated every cycle:
  - `done_i`=1, or
  - `req_i[grant_idx_o]`=0, or
  - `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD-1`, and `(req_i & ~grant_o)`≠0. This case is the timeout.
- **On release.**
  - `ptr` takes `grant_idx_o`.
  - Next edge: `grant_o`=0, `grant_val_o`=0, state goes to IDLE.
  - `timeout_o`=1 for that one cycle only if the release came from the timeout alone.
- **Simultaneous events.**
  - `done_i` together with timeout: a normal release, `timeout_o`=0.
  - Request drop together with timeout: also a normal release.
- **Timeout with nobody waiting.** If the timeout count is reached but no other requester is waiting, the owner keeps the grant. `hold_cnt` saturates at `MAX_HOLD-1`, and the timeout fires on the first later cycle in which another request appears.
- **Ignored inputs.** `done_i` is ignored in IDLE. Requests from non-owners never affect the current grant except through the timeout.
- **Invariants.**
  - `grant_o` is always 0 or one-hot.
  - `grant_val_o` == `|grant_o`.
  - `grant_o`==`1<<grant_idx_o` whenever `grant_val_o`=1.
- **Reset mid-operation.** Asserting `arst_i` drops `grant_o` immediately (asynchronously) and restores all reset values. Arbitration resumes on the first edge after deassertion, with requester 0 first.

## Timing
- Request latency: `req_i` high in IDLE cycle N gives `grant_o` valid from the edge ending N, visible in cycle N+1.
- Release: a release condition in cycle M gives `grant_o`=0 in M+1 (IDLE) and the next grant visible in M+2. There is a mandatory one-cycle bus gap between owners.
- Hold: the owner holds at most `MAX_HOLD` cycles when others are waiting.
- Worst-case wait for a continuously requesting line is `(WIDTH-1)*(MAX_HOLD+1)+1` cycles.
- No combinational path from inputs to outputs.

## Test plan
- **Reset priority:** reset, then `req_i`=4'b1111 held, `done_i` pulsed each GRANT cycle → grants 0,1,2,3,0 in that order, each one cycle with a one-cycle gap, `timeout_o`=0 throughout.
- **Wrap search:** last owner 2, then `req_i`=4'b0011 → grant 0 (wrap past 3), then 1; with `req_i`=4'b0100 alone → grant 2 regardless of `ptr`.
- **Timeout:** `MAX_HOLD`=16, owner 1 holds `req_i[1]`, `req_i[3]` asserted at cycle 3 of GRANT → `grant_o`=4'b0010 for exactly 16 cycles, then 0 with `timeout_o`=1 for one cycle, then 4'b1000.
- **No-waiter hold:** only `req_i[2]` high for 40 cycles → `grant_o`=4'b0100 continuously, `timeout_o` never set. Raising `req_i[0]` at cycle 40 → release on the next edge, `timeout_o` pulses once.
- **Request drop and `done_i`/timeout tie:** drop `req_i[owner]` → release next edge, `timeout_o`=0. `done_i` asserted in the timeout cycle → `timeout_o`=0.
- **Async reset mid-grant:** pulse `arst_i` between clock edges while `grant_o`=4'b1000 → `grant_o`=0 and `grant_val_o`=0 before the next edge. After release with `req_i`=4'b1001, the first grant is 4'b0001.
